// File: rtl/conf_sequencer_pkg.sv
// Shared types and defaults for the parameter-frame sequencer.
// Frame layout, FSM states and datapath reset values.
package conf_sequencer_pkg;

    localparam int CONF_PAR_MAX   = 5;
    localparam int DEF_REF_GEN    = 127;
    localparam int DEF_PRED       = 30;
    localparam int DEF_OCD_LVL    = 87;
    localparam int DEF_INT_FREQ   = 10;
    localparam int DEF_INT_PW     = 1;
    localparam int OCD_LVL_MAX    = 200;
    localparam int PW_MAX         = 255;
    localparam int PW_RAMP_STEP   = 1;
    localparam int FAULT_HOLD_CYC = 1000;
    localparam int HOLD_W         = $clog2(FAULT_HOLD_CYC + 1);

    typedef enum logic [2:0] {
        INT_PW   = 3'd0,
        INT_FREQ = 3'd1,
        OCD_LVL  = 3'd2,
        PRED     = 3'd3,
        REF_GEN  = 3'd4
    } conf_idx_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PENDING,
        S_APPLY,
        S_RUN,
        S_FAULT
    } conf_state_t;

    typedef struct packed {
        logic [7:0] ref_gen;
        logic [7:0] pred;
        logic [7:0] ocd_lvl;
        logic [7:0] int_freq;
        logic [7:0] int_pw;
    } conf_frame_t;

    function automatic logic [7:0] clamp8(
        input logic [7:0] v,
        input logic [7:0] mx
    );
        return (v > mx) ? mx : v;
    endfunction

endpackage

// File: rtl/conf_sequencer_pw_ramp.sv
// Pulse-width soft ramp: target register, burst falling-edge
// detector and saturating step toward the target.
module pw_ramp
    import conf_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       burst_active,
    input  logic       ramp_en,
    input  logic       load,
    input  logic [7:0] load_pw,
    input  logic       fault_clr,
    output logic [7:0] pw
);

    logic       burst_q;
    logic [7:0] target;
    logic       fall;
    logic       dec_imm;
    logic [8:0] pw_inc;
    logic [7:0] pw_sat;

    assign fall    = burst_q & ~burst_active;
    assign dec_imm = load_pw < pw;
    assign pw_inc  = {1'b0, pw} + 9'(PW_RAMP_STEP);
    assign pw_sat  = pw_inc[8] ? 8'hFF : pw_inc[7:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            burst_q <= 1'b0;
            target  <= '0;
            pw      <= 8'(DEF_INT_PW);
        end else begin
            burst_q <= burst_active;
            if (fault_clr) begin
                target <= 8'(DEF_INT_PW);
                pw     <= 8'(DEF_INT_PW);
            end else if (load) begin
                target <= load_pw;
                // Decreases take effect at once; only increases ramp.
                if (dec_imm)
                    pw <= load_pw;
            end else if (ramp_en && fall && pw < target) begin
                pw <= (pw_sat > target) ? target : pw_sat;
            end
        end
    end

endmodule

// File: rtl/conf_sequencer.sv
// Validates received parameter frames and applies them to the
// live datapath between bursts, with over-current lockout.
module conf_sequencer
    import conf_sequencer_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         frame_valid,
    input  logic [CONF_PAR_MAX-1:0][7:0] conf_in,
    input  logic                         burst_active,
    input  logic                         ocd_trip,
    output logic [7:0]                   ref_gen_par,
    output logic [7:0]                   pred_shift,
    output logic [7:0]                   ocd_lvl_par,
    output logic [7:0]                   int_freq_par,
    output logic [7:0]                   int_pw_par,
    output logic                         enable,
    output logic                         fault,
    output logic                         reject
);

    conf_state_t       state;
    conf_frame_t       shadow;
    conf_frame_t       frame;
    logic [HOLD_W-1:0] hold;
    logic              frame_ok;
    logic              ramp_load;
    logic              ramp_run;

    assign frame_ok = (conf_in[INT_FREQ] != 8'd0)
                    && (conf_in[INT_PW] != 8'd0);

    always_comb begin
        frame          = '0;
        frame.ref_gen  = conf_in[REF_GEN];
        frame.pred     = conf_in[PRED];
        frame.ocd_lvl  = clamp8(conf_in[OCD_LVL], 8'(OCD_LVL_MAX));
        frame.int_freq = conf_in[INT_FREQ];
        frame.int_pw   = clamp8(conf_in[INT_PW], 8'(PW_MAX));
    end

    assign ramp_load = (state == S_APPLY) && !ocd_trip;
    assign ramp_run  = (state == S_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            shadow       <= '0;
            hold         <= '0;
            ref_gen_par  <= 8'(DEF_REF_GEN);
            pred_shift   <= 8'(DEF_PRED);
            ocd_lvl_par  <= 8'(DEF_OCD_LVL);
            int_freq_par <= 8'(DEF_INT_FREQ);
            enable       <= 1'b0;
            fault        <= 1'b0;
            reject       <= 1'b0;
        end else begin
            reject <= 1'b0;
            if (ocd_trip) begin
                enable <= 1'b0;
                fault  <= 1'b1;
                shadow <= '0;
                hold   <= HOLD_W'(FAULT_HOLD_CYC);
                state  <= S_FAULT;
            end else begin
                unique case (state)
                    S_IDLE, S_PENDING, S_RUN: begin
                        if (frame_valid) begin
                            if (frame_ok) begin
                                shadow <= frame;
                                state  <= burst_active ? S_PENDING
                                                       : S_APPLY;
                            end else begin
                                reject <= 1'b1;
                            end
                        end else if (state == S_PENDING
                                     && !burst_active) begin
                            state <= S_APPLY;
                        end
                    end
                    S_APPLY: begin
                        ref_gen_par  <= shadow.ref_gen;
                        pred_shift   <= shadow.pred;
                        ocd_lvl_par  <= shadow.ocd_lvl;
                        int_freq_par <= shadow.int_freq;
                        enable       <= 1'b1;
                        state        <= S_RUN;
                    end
                    S_FAULT: begin
                        // Leave lockout with enable low; a new frame re-arms.
                        if (hold <= HOLD_W'(1)) begin
                            hold  <= '0;
                            fault <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            hold <= hold - HOLD_W'(1);
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    pw_ramp u_pw_ramp (
        .clk          (clk),
        .rst          (rst),
        .burst_active (burst_active),
        .ramp_en      (ramp_run),
        .load         (ramp_load),
        .load_pw      (shadow.int_pw),
        .fault_clr    (ocd_trip),
        .pw           (int_pw_par)
    );

endmodule

// File: tb/tb_conf_sequencer.sv
// Directed plus randomized checks of conf_sequencer against a
// behavioural reference model.
module tb_conf_sequencer;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            frame_valid = 1'b0;
    logic [4:0][7:0] conf_in = '0;
    logic            burst_active = 1'b0;
    logic            ocd_trip = 1'b0;
    logic [7:0]      ref_gen_par, pred_shift, ocd_lvl_par;
    logic [7:0]      int_freq_par, int_pw_par;
    logic            enable, fault, reject;

    int n_cmp = 0;
    int n_bad = 0;

    conf_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .frame_valid  (frame_valid),
        .conf_in      (conf_in),
        .burst_active (burst_active),
        .ocd_trip     (ocd_trip),
        .ref_gen_par  (ref_gen_par),
        .pred_shift   (pred_shift),
        .ocd_lvl_par  (ocd_lvl_par),
        .int_freq_par (int_freq_par),
        .int_pw_par   (int_pw_par),
        .enable       (enable),
        .fault        (fault),
        .reject       (reject)
    );

    always #5 clk = ~clk;

    localparam int M_IDLE = 0, M_WAIT = 1, M_APPLYING = 2;
    localparam int M_RUNNING = 3, M_LOCKED = 4;
    localparam int HOLD = 1000;

    int mode, hold_left;
    int m_ref, m_pred, m_ocd, m_freq, m_pw, m_tgt;
    int m_en, m_fault, m_rej;
    int sh[5];
    bit bprev;

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_step();
        bit fall;
        fall  = bprev && !burst_active;
        bprev = burst_active;
        m_rej = 0;
        if (rst) begin
            m_ref = 127; m_pred = 30; m_ocd = 87;
            m_freq = 10; m_pw = 1; m_tgt = 0;
            m_en = 0; m_fault = 0; mode = M_IDLE;
            bprev = 0;
        end else if (ocd_trip) begin
            m_en = 0; m_fault = 1; m_pw = 1; m_tgt = 1;
            hold_left = HOLD; mode = M_LOCKED;
        end else begin
            if (mode == M_RUNNING && fall)
                m_pw = imin(m_pw + 1, m_tgt);
            case (mode)
                M_LOCKED: begin
                    if (hold_left == 1) begin
                        m_fault = 0; mode = M_IDLE;
                    end else hold_left--;
                end
                M_APPLYING: begin
                    m_ref = sh[4]; m_pred = sh[3]; m_ocd = sh[2];
                    m_freq = sh[1]; m_tgt = sh[0];
                    if (sh[0] < m_pw) m_pw = sh[0];
                    m_en = 1; mode = M_RUNNING;
                end
                default: begin
                    if (frame_valid) begin
                        if (conf_in[1] == 0 || conf_in[0] == 0) begin
                            m_rej = 1;
                        end else begin
                            sh[4] = conf_in[4]; sh[3] = conf_in[3];
                            sh[2] = imin(conf_in[2], 200);
                            sh[1] = conf_in[1]; sh[0] = conf_in[0];
                            mode = burst_active ? M_WAIT : M_APPLYING;
                        end
                    end else if (mode == M_WAIT && !burst_active) begin
                        mode = M_APPLYING;
                    end
                end
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".ref"},   32'(ref_gen_par),  32'(m_ref));
        chk({tag, ".pred"},  32'(pred_shift),   32'(m_pred));
        chk({tag, ".ocd"},   32'(ocd_lvl_par),  32'(m_ocd));
        chk({tag, ".freq"},  32'(int_freq_par), 32'(m_freq));
        chk({tag, ".pw"},    32'(int_pw_par),   32'(m_pw));
        chk({tag, ".en"},    32'(enable),       32'(m_en));
        chk({tag, ".fault"}, 32'(fault),        32'(m_fault));
        chk({tag, ".rej"},   32'(reject),       32'(m_rej));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic send(input int r, input int p, input int o,
                        input int f, input int w);
        conf_in[4] = 8'(r); conf_in[3] = 8'(p); conf_in[2] = 8'(o);
        conf_in[1] = 8'(f); conf_in[0] = 8'(w);
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
    endtask

    task automatic pulse();
        burst_active = 1'b1; tick();
        burst_active = 1'b0; tick();
    endtask

    initial begin
        // 1: reset
        rst = 1'b1; tick(); tick();
        chk_all("reset");
        chk("reset.ref_c", 32'(ref_gen_par), 127);
        chk("reset.pw_c", 32'(int_pw_par), 1);
        rst = 1'b0; tick();

        // 2: apply with clamp, then ramp 1->5 and hold
        send(200, 40, 250, 20, 5);
        tick();
        chk_all("apply");
        chk("apply.ocd_c", 32'(ocd_lvl_par), 200);
        chk("apply.en_c", 32'(enable), 1);
        for (int i = 0; i < 4; i++) pulse();
        chk_all("ramp");
        chk("ramp.pw_c", 32'(int_pw_par), 5);
        pulse(); pulse();
        chk("ramp.hold_c", 32'(int_pw_par), 5);

        // 3: frames during a burst; latest wins
        burst_active = 1'b1; tick();
        send(11, 12, 13, 14, 5);
        tick();
        send(21, 22, 23, 24, 5);
        tick();
        chk("pend.ref_c", 32'(ref_gen_par), 200);
        burst_active = 1'b0; tick();
        chk("pend.still_c", 32'(ref_gen_par), 200);
        tick();
        chk_all("pend");
        chk("pend.ref2_c", 32'(ref_gen_par), 21);

        // 4: invalid frame
        send(99, 99, 99, 99, 0);
        chk_all("rej");
        chk("rej.pulse_c", 32'(reject), 1);
        tick();
        chk("rej.drop_c", 32'(reject), 0);
        chk("rej.ref_c", 32'(ref_gen_par), 21);

        // 5: trip with simultaneous frame
        ocd_trip = 1'b1;
        send(50, 50, 50, 50, 50);
        ocd_trip = 1'b0;
        chk_all("trip");
        chk("trip.pw_c", 32'(int_pw_par), 1);
        chk("trip.rej_c", 32'(reject), 0);
        for (int i = 0; i < HOLD - 1; i++) tick();
        chk("hold.fault_c", 32'(fault), 1);
        tick();
        chk_all("unlock");
        chk("unlock.fault_c", 32'(fault), 0);
        tick(); tick();
        chk("unlock.en_c", 32'(enable), 0);

        // 6: lowering pw target applies at once
        send(30, 31, 32, 33, 5);
        tick();
        for (int i = 0; i < 4; i++) pulse();
        chk("lower.pre_c", 32'(int_pw_par), 5);
        send(30, 31, 32, 33, 2);
        tick();
        chk_all("lower");
        chk("lower.pw_c", 32'(int_pw_par), 2);

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(3) == 0)
                burst_active = ~burst_active;
            frame_valid = ($urandom_range(7) == 0);
            for (int k = 0; k < 5; k++)
                conf_in[k] = 8'($urandom);
            if ($urandom_range(5) == 0) conf_in[0] = 8'd0;
            if ($urandom_range(5) == 0) conf_in[1] = 8'd0;
            if ($urandom_range(3) == 0)
                conf_in[0] = 8'($urandom_range(1, 8));
            ocd_trip = ($urandom_range(599) == 0);
            rst = ($urandom_range(1999) == 0);
            tick();
            chk_all("rand");
        end
        rst = 1'b0; ocd_trip = 1'b0; frame_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/conf_sequencer.md
Name: conf_sequencer

Overview:
- Sits between the `uart` parameter frame and the live datapath parameters: `ref_gen` inp, `pred` shift, `ocd_lvl` pw_par, `interrupter` freq_par/pw_par.
- Captures a received frame and validates it. Applies it only between interrupter bursts, soft-ramps pulse width upward, and forces a lockout on over-current.
- Replaces the hard-wired 8'd constants at top level.

Parameters:
- CONF_PAR_MAX, 5, number of 8-bit config parameters per frame.
- DEF_REF_GEN, 127, ref_gen_par reset value.
- DEF_PRED, 30, pred_shift reset value.
- DEF_OCD_LVL, 87, ocd_lvl_par reset value.
- DEF_INT_FREQ, 10, int_freq_par reset value.
- DEF_INT_PW, 1, int_pw_par reset/fault value.
- OCD_LVL_MAX, 200, clamp ceiling for ocd_lvl_par.
- PW_MAX, 255, clamp ceiling for pw target.
- PW_RAMP_STEP, 1, pw increment applied per completed burst.
- FAULT_HOLD_CYC, 1000, lockout duration in clk cycles (counter width = $clog2(FAULT_HOLD_CYC+1)).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- frame_valid  in  1  one-cycle pulse: complete frame present on conf_in
- conf_in  in  CONF_PAR_MAX x 8  frame; [4] ref_gen, [3] pred, [2] ocd_lvl, [1] int_freq, [0] int_pw
- burst_active  in  1  high while interrupter output window is open
- ocd_trip  in  1  over-current comparator (int_ocd), already synchronised
- ref_gen_par  out  8  to ref_gen inp
- pred_shift  out  8  to pred shift
- ocd_lvl_par  out  8  to ocd_lvl pw_par
- int_freq_par  out  8  to interrupter freq_par
- int_pw_par  out  8  to interrupter pw_par
- enable  out  1  interrupter gate enable
- fault  out  1  lockout indicator
- reject  out  1  one-cycle pulse: frame refused

Behaviour:
- All outputs are registered.
- Reset (rst sampled high at a clk edge):
  - All parameter outputs go to their DEF_* values.
  - enable=0, fault=0, reject=0.
  - Shadow register and ramp target are cleared; state=IDLE.
- States: IDLE, PENDING, APPLY, RUN, FAULT.
- Frame capture, in IDLE/PENDING/RUN, when frame_valid=1:
  - If conf_in[1]==0 or conf_in[0]==0, the frame is discarded and reject=1 on the next cycle; state is unchanged.
  - Otherwise the frame goes to shadow with ocd clamped to OCD_LVL_MAX and pw clamped to PW_MAX; state goes to PENDING.
  - Latest frame wins: a frame arriving in PENDING overwrites the shadow.
- PENDING -> APPLY on the first cycle burst_active=0. Entry is immediate if burst_active is already 0.
- APPLY (single cycle), on the next edge:
  - ref_gen_par, pred_shift, ocd_lvl_par and int_freq_par take the shadow values.
  - pw_target <= shadow pw. If shadow pw < int_pw_par, int_pw_par takes it immediately (decreases are never ramped).
  - enable <= 1; state goes to RUN.
  - Latency: frame_valid with burst_active low -> outputs updated 2 cycles later.
- RUN ramp:
  - On each burst_active falling edge (registered 1->0 detect), int_pw_par <= min(int_pw_par + PW_RAMP_STEP, pw_target).
  - Compute in 9 bits, then saturate to 8 bits.
  - No change while burst_active=1.
- Fault entry:
  - ocd_trip=1 in any non-reset state -> next cycle: enable=0, fault=1, int_pw_par=DEF_INT_PW, pw_target=DEF_INT_PW, shadow invalidated, hold counter loaded; state goes to FAULT.
  - ocd_trip has priority over frame_valid and over APPLY in the same cycle; that frame is discarded with no reject pulse.
- FAULT:
  - frame_valid is ignored.
  - ocd_trip=1 reloads the counter.
  - Counter reaching 0 -> fault=0, state goes to IDLE with enable still 0.
  - A new valid frame is required to re-enable; the ramp then restarts from DEF_INT_PW.
- rst mid-ramp or mid-fault: full reset as above, with no residual ramp state.

Decomposition:
- Shared package entries:
  - conf_idx_t enum for frame indices: REF_GEN=4, PRED=3, OCD_LVL=2, INT_FREQ=1, INT_PW=0.
  - conf_state_t enum.
  - DEF_* defaults and CONF_PAR_MAX, alongside the existing common.sv constants.
- One sub-module, `pw_ramp`: holds pw_target, edge detector and saturating increment. Inputs: load, decrease-immediate, fault clear.

Test Plan:
1. rst=1 for 2 cycles -> ref=127, pred=30, ocd=87, freq=10, pw=1, enable=0, fault=0.
2. Frame {200,40,250,20,5} with burst_active=0 -> 2 cycles later ref=200, pred=40, ocd=200 (clamped), freq=20, enable=1. pw: 1->2->3->4->5 over 4 burst falling edges, then holds at 5.
3. Frame sent while burst_active=1 -> outputs unchanged until burst_active falls, then updated at +1 cycle. A second frame during PENDING -> only the second frame is applied.
4. Frame with int_pw=0 -> reject pulses once, all outputs unchanged, state stays RUN.
5. In RUN with pw=5, assert ocd_trip one cycle together with frame_valid -> next cycle enable=0, fault=1, pw=1, frame dropped. fault clears after FAULT_HOLD_CYC cycles; enable stays 0 until a valid frame arrives.
6. Lower pw target: RUN at pw=5, frame pw=2 -> pw=2 at APPLY immediately, no ramp steps.
